// File: rtl/uart_frame_rx.sv
// Purpose : assembles 7-byte sync/XOR-checksummed frames from the UART RX FIFO and
//           publishes remote player state only from frames whose checksum matches.
// Latency : outputs and frame_valid update one cycle after the checksum byte is popped.
// Backpressure: none; rd_uart = !rx_empty, so one byte is consumed every cycle one is available.
//
// Ports:
//   clk, rst           - 65 MHz clock, asynchronous active-high reset
//   read_data/rx_empty - show-ahead FIFO head byte and empty flag
//   rd_uart            - FIFO pop (combinational)
//   current_x/y_1/2    - remote player tile positions
//   player1/2_collision, selected_player - decoded from the flags byte
//   frame_valid        - one-cycle pulse when the outputs above update
//   err_count          - saturating count of frames dropped (bad checksum or timeout)
module uart_frame_rx #(
    parameter logic [7:0] SYNC_BYTE      = 8'hA5,
    parameter int         TIMEOUT_CYCLES = 65000,
    parameter int         TMR_W          = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] read_data,
    input  logic       rx_empty,
    output logic       rd_uart,
    output logic [7:0] current_x_1,
    output logic [7:0] current_y_1,
    output logic [7:0] current_x_2,
    output logic [7:0] current_y_2,
    output logic       player1_collision,
    output logic       player2_collision,
    output logic [1:0] selected_player,
    output logic       frame_valid,
    output logic [7:0] err_count
);

    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        PAYLOAD = 2'd1,
        CHECK   = 2'd2
    } state_t;

    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

    state_t            state_q, state_d;
    logic [2:0]        idx_q, idx_d;
    logic [7:0]        chk_q, chk_d;
    logic [TMR_W-1:0]  tmr_q, tmr_d;

    // Shadow copy of the frame under assembly; only promoted on a good checksum.
    logic [7:0]        sx1_q, sx1_d;
    logic [7:0]        sy1_q, sy1_d;
    logic [7:0]        sx2_q, sx2_d;
    logic [7:0]        sy2_q, sy2_d;
    logic [3:0]        sflg_q, sflg_d;

    // Published state.
    logic [7:0]        x1_q, x1_d;
    logic [7:0]        y1_q, y1_d;
    logic [7:0]        x2_q, x2_d;
    logic [7:0]        y2_q, y2_d;
    logic [3:0]        flg_q, flg_d;
    logic              fv_q, fv_d;
    logic [7:0]        err_q, err_d;

    logic              accept;
    logic              err_inc;

    // The FIFO is drained unconditionally; framing decisions never stall it.
    assign rd_uart = !rx_empty && !rst;
    assign accept  = rd_uart;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        chk_d   = chk_q;
        tmr_d   = tmr_q;
        sx1_d   = sx1_q;
        sy1_d   = sy1_q;
        sx2_d   = sx2_q;
        sy2_d   = sy2_q;
        sflg_d  = sflg_q;
        x1_d    = x1_q;
        y1_d    = y1_q;
        x2_d    = x2_q;
        y2_d    = y2_q;
        flg_d   = flg_q;
        fv_d    = 1'b0;
        err_inc = 1'b0;

        case (state_q)
            HUNT: begin
                tmr_d = '0;
                // Non-sync bytes are line noise between frames, not errors.
                if (accept && (read_data == SYNC_BYTE)) begin
                    state_d = PAYLOAD;
                    idx_d   = 3'd1;
                    chk_d   = 8'h00;
                end
            end

            PAYLOAD, CHECK: begin
                if (accept) begin
                    // An arriving byte always beats a coincident timeout.
                    tmr_d = '0;
                    if (state_q == PAYLOAD) begin
                        chk_d = chk_q ^ read_data;
                        case (idx_q)
                            3'd1:    sx1_d  = read_data;
                            3'd2:    sy1_d  = read_data;
                            3'd3:    sx2_d  = read_data;
                            3'd4:    sy2_d  = read_data;
                            3'd5:    sflg_d = read_data[3:0];
                            default: ;
                        endcase
                        idx_d = idx_q + 3'd1;
                        if (idx_q == 3'd5) begin
                            state_d = CHECK;
                        end
                    end else begin
                        if (read_data == chk_q) begin
                            x1_d  = sx1_q;
                            y1_d  = sy1_q;
                            x2_d  = sx2_q;
                            y2_d  = sy2_q;
                            flg_d = sflg_q;
                            fv_d  = 1'b1;
                        end else begin
                            err_inc = 1'b1;
                        end
                        state_d = HUNT;
                        idx_d   = 3'd0;
                    end
                end else if (tmr_q == TMR_LAST) begin
                    // Stalled frame: abandon it. Shadow contents are simply
                    // overwritten by the next frame, so they need no clearing.
                    state_d = HUNT;
                    idx_d   = 3'd0;
                    tmr_d   = '0;
                    err_inc = 1'b1;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end

            default: begin
                state_d = HUNT;
                idx_d   = 3'd0;
                tmr_d   = '0;
            end
        endcase

        err_d = (err_inc && (err_q != 8'hFF)) ? err_q + 8'd1 : err_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= HUNT;
            idx_q   <= 3'd0;
            chk_q   <= 8'h00;
            tmr_q   <= '0;
            sx1_q   <= 8'h00;
            sy1_q   <= 8'h00;
            sx2_q   <= 8'h00;
            sy2_q   <= 8'h00;
            sflg_q  <= 4'h0;
            x1_q    <= 8'h00;
            y1_q    <= 8'h00;
            x2_q    <= 8'h00;
            y2_q    <= 8'h00;
            flg_q   <= 4'h0;
            fv_q    <= 1'b0;
            err_q   <= 8'h00;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            chk_q   <= chk_d;
            tmr_q   <= tmr_d;
            sx1_q   <= sx1_d;
            sy1_q   <= sy1_d;
            sx2_q   <= sx2_d;
            sy2_q   <= sy2_d;
            sflg_q  <= sflg_d;
            x1_q    <= x1_d;
            y1_q    <= y1_d;
            x2_q    <= x2_d;
            y2_q    <= y2_d;
            flg_q   <= flg_d;
            fv_q    <= fv_d;
            err_q   <= err_d;
        end
    end

    // Flags byte layout: {4'b0, sel[1:0], p2col, p1col}.
    assign current_x_1       = x1_q;
    assign current_y_1       = y1_q;
    assign current_x_2       = x2_q;
    assign current_y_2       = y2_q;
    assign player1_collision = flg_q[0];
    assign player2_collision = flg_q[1];
    assign selected_player   = flg_q[3:2];
    assign frame_valid       = fv_q;
    assign err_count         = err_q;

endmodule

// File: tb/tb_uart_frame_rx.sv
// Purpose : directed self-checking bench for uart_frame_rx.
// Latency : inputs driven on the falling edge, outputs sampled on the falling edge.
// Backpressure: FIFO modelled as show-ahead; a byte is held for exactly one rising edge.
module tb_uart_frame_rx;

    // Shortened idle limit so both timeout scenarios fit in a short run;
    // the counter logic is identical for any value.
    localparam int TO = 1000;

    logic       clk;
    logic       rst;
    logic [7:0] read_data;
    logic       rx_empty;
    logic       rd_uart;
    logic [7:0] current_x_1, current_y_1, current_x_2, current_y_2;
    logic       player1_collision, player2_collision;
    logic [1:0] selected_player;
    logic       frame_valid;
    logic [7:0] err_count;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_rd  = 1'b0;
    int err_exp = 0;

    uart_frame_rx #(
        .SYNC_BYTE      (8'hA5),
        .TIMEOUT_CYCLES (TO),
        .TMR_W          (16)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .read_data         (read_data),
        .rx_empty          (rx_empty),
        .rd_uart           (rd_uart),
        .current_x_1       (current_x_1),
        .current_y_1       (current_y_1),
        .current_x_2       (current_x_2),
        .current_y_2       (current_y_2),
        .player1_collision (player1_collision),
        .player2_collision (player2_collision),
        .selected_player   (selected_player),
        .frame_valid       (frame_valid),
        .err_count         (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {x1, y1, x2, y2, sel, p2col, p1col}
    logic [35:0] outs;
    assign outs = {current_x_1, current_y_1, current_x_2, current_y_2,
                   selected_player, player2_collision, player1_collision};

    function automatic logic [35:0] exp_outs(input logic [7:0] x1, input logic [7:0] y1,
                                             input logic [7:0] x2, input logic [7:0] y2,
                                             input logic [7:0] fl);
        return {x1, y1, x2, y2, fl[3:2], fl[1], fl[0]};
    endfunction

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // Called at a falling edge; the byte is consumed at the next rising edge.
    task automatic send_byte(input logic [7:0] b);
        read_data = b;
        rx_empty  = 1'b0;
        if (chk_rd) begin
            #1;
            check("rd_uart_high", {63'd0, rd_uart}, 64'd1);
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        rx_empty = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] x1, input logic [7:0] y1,
                              input logic [7:0] x2, input logic [7:0] y2,
                              input logic [7:0] fl, input logic [7:0] ck);
        send_byte(8'hA5);
        send_byte(x1);
        send_byte(y1);
        send_byte(x2);
        send_byte(y2);
        send_byte(fl);
        send_byte(ck);
        rx_empty = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1);
    end

    initial begin
        rst       = 1'b1;
        read_data = 8'h00;
        rx_empty  = 1'b0;
        #12;
        // Reset state, with the FIFO reporting data: no pop while in reset.
        check("reset_outs", {28'd0, outs}, 64'd0);
        check("reset_fv", {63'd0, frame_valid}, 64'd0);
        check("reset_err", {56'd0, err_count}, 64'd0);
        check("reset_rd", {63'd0, rd_uart}, 64'd0);
        rx_empty = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        idle(2);

        // 1: valid frame, checksum 10^20^30^40^0B = 4B
        send_frame(8'h10, 8'h20, 8'h30, 8'h40, 8'h0B, 8'h4B);
        check("t1_fv", {63'd0, frame_valid}, 64'd1);
        check("t1_outs", {28'd0, outs}, {28'd0, exp_outs(8'h10, 8'h20, 8'h30, 8'h40, 8'h0B)});
        check("t1_err", {56'd0, err_count}, 64'd0);
        idle(1);
        check("t1_fv_pulse", {63'd0, frame_valid}, 64'd0);

        // 2: same frame with a wrong checksum
        send_frame(8'h10, 8'h20, 8'h30, 8'h40, 8'h0B, 8'h4C);
        err_exp = 1;
        check("t2_fv", {63'd0, frame_valid}, 64'd0);
        check("t2_err", {56'd0, err_count}, 64'(err_exp));
        idle(1);
        check("t2_outs_held", {28'd0, outs}, {28'd0, exp_outs(8'h10, 8'h20, 8'h30, 8'h40, 8'h0B)});

        // 3: leading garbage then a valid frame, rd_uart high for every byte
        chk_rd = 1'b1;
        send_byte(8'h00);
        send_byte(8'hFF);
        send_byte(8'h13);
        send_frame(8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h01);
        chk_rd = 1'b0;
        check("t3_fv", {63'd0, frame_valid}, 64'd1);
        check("t3_outs", {28'd0, outs}, {28'd0, exp_outs(8'h01, 8'h02, 8'h03, 8'h04, 8'h05)});
        check("t3_err", {56'd0, err_count}, 64'(err_exp));
        idle(3);

        // 4a: stall after B2; nothing happens until the TO-th idle cycle
        send_byte(8'hA5);
        send_byte(8'h11);
        send_byte(8'h22);
        idle(TO - 1);
        check("t4_pre_timeout_err", {56'd0, err_count}, 64'(err_exp));
        idle(1);
        err_exp = err_exp + 1;
        check("t4_timeout_err", {56'd0, err_count}, 64'(err_exp));
        // Back in HUNT, so this A5 starts a new frame.
        send_frame(8'h11, 8'h22, 8'h33, 8'h44, 8'h06, 8'h42);
        check("t4_fv", {63'd0, frame_valid}, 64'd1);
        check("t4_outs", {28'd0, outs}, {28'd0, exp_outs(8'h11, 8'h22, 8'h33, 8'h44, 8'h06)});
        check("t4_err_after", {56'd0, err_count}, 64'(err_exp));
        idle(2);

        // 4b: byte arrives on the cycle the timeout would fire; upper flag nibble ignored
        send_byte(8'hA5);
        send_byte(8'h12);
        send_byte(8'h34);
        idle(TO - 1);
        send_byte(8'h56);
        send_byte(8'h78);
        send_byte(8'hF8);
        send_byte(8'hF0);
        rx_empty = 1'b1;
        check("t4b_fv", {63'd0, frame_valid}, 64'd1);
        check("t4b_outs", {28'd0, outs}, {28'd0, exp_outs(8'h12, 8'h34, 8'h56, 8'h78, 8'hF8)});
        check("t4b_err", {56'd0, err_count}, 64'(err_exp));
        idle(1);

        // Sync value inside payload and as the checksum is plain data
        send_frame(8'hA5, 8'h01, 8'h02, 8'h03, 8'h00, 8'hA5);
        check("sync_data_fv", {63'd0, frame_valid}, 64'd1);
        check("sync_data_outs", {28'd0, outs}, {28'd0, exp_outs(8'hA5, 8'h01, 8'h02, 8'h03, 8'h00)});
        idle(1);

        // 5: 256 bad frames saturate the error counter at 255
        for (int i = 0; i < 256; i++) begin
            send_frame(8'h10, 8'h20, 8'h30, 8'h40, 8'h0B, 8'h00);
            err_exp = (err_exp == 255) ? 255 : err_exp + 1;
            check("t5_err", {56'd0, err_count}, 64'(err_exp));
            check("t5_fv", {63'd0, frame_valid}, 64'd0);
        end
        check("t5_outs_held", {28'd0, outs}, {28'd0, exp_outs(8'hA5, 8'h01, 8'h02, 8'h03, 8'h00)});
        idle(1);

        // 6: reset after B3, rest of the aborted frame is dropped in HUNT
        send_byte(8'hA5);
        send_byte(8'h10);
        send_byte(8'h20);
        send_byte(8'h30);
        read_data = 8'h40;
        rst = 1'b1;
        #1;
        err_exp = 0;
        check("t6_rst_outs", {28'd0, outs}, 64'd0);
        check("t6_rst_err", {56'd0, err_count}, 64'd0);
        check("t6_rst_rd", {63'd0, rd_uart}, 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        send_byte(8'h40);
        send_byte(8'h0B);
        send_byte(8'h4B);
        rx_empty = 1'b1;
        check("t6_tail_fv", {63'd0, frame_valid}, 64'd0);
        check("t6_tail_err", {56'd0, err_count}, 64'd0);
        check("t6_tail_outs", {28'd0, outs}, 64'd0);
        idle(1);
        send_frame(8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h01);
        check("t6_fv", {63'd0, frame_valid}, 64'd1);
        check("t6_outs", {28'd0, outs}, {28'd0, exp_outs(8'h01, 8'h02, 8'h03, 8'h04, 8'h05)});
        check("t6_err", {56'd0, err_count}, 64'd0);
        idle(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
